// File: rtl/b8_pipe_pkg.sv
// Shared types for the decoder-to-Ex pipeline register: payload struct, widths, skid FSM states.
// DU_REG_DEBUG_INST_EN adds a 32-bit raw instruction word to the payload.
package b8_pipe_pkg;

    localparam int XLEN   = 64;
    localparam int ADDR_W = 32;
    localparam int PID_W  = 2;

    typedef struct packed {
        logic [4:0]        rd_addr;
        logic              rd_write_enable;
        logic [ADDR_W-1:0] inst_addr;
`ifdef DU_REG_DEBUG_INST_EN
        logic [31:0]       inst;
`endif
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [6:0]        op_code;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [5:0]        shamt;
        logic [PID_W-1:0]  pid;
    } du_payload_t;

    localparam int PLD_W = $bits(du_payload_t);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer (MAIN drives the output, SKID catches the in-flight beat) whose
// upstream ready is registered, so downstream ready never reaches it combinationally.
module pipe_skid_buf
    import b8_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    skid_state_t      state_reg;
    skid_state_t      state_next;
    logic             ready_reg;
    logic [WIDTH-1:0] main_reg;
    logic [WIDTH-1:0] skid_reg;
    logic             accept;
    logic             release_beat;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    assign accept       = in_valid && ready_reg;
    assign release_beat = (state_reg != ST_EMPTY) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: if (accept) state_next = ST_ONE;
                ST_ONE: begin
                    if (accept && !release_beat)      state_next = ST_FULL;
                    else if (!accept && release_beat) state_next = ST_EMPTY;
                end
                ST_FULL:  if (release_beat) state_next = ST_ONE;
                default:  state_next = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid      = (state_reg != ST_EMPTY);
        count          = state_reg;
        in_ready       = ready_reg;
        out_data       = main_reg;
        load_main_in   = ((state_reg == ST_EMPTY) && accept) ||
                         ((state_reg == ST_ONE) && accept && release_beat);
        load_main_skid = (state_reg == ST_FULL) && release_beat;
        load_skid      = (state_reg == ST_ONE) && accept && !release_beat;
    end

    // Held low through reset; afterwards it simply tracks "SKID will be free".
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_reg <= 1'b0;
        end else begin
            ready_reg <= (state_next != ST_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_reg <= '0;
            skid_reg <= '0;
        end else if (!flush) begin
            if (load_main_in) begin
                main_reg <= in_data;
            end else if (load_main_skid) begin
                main_reg <= skid_reg;
            end
            if (load_skid) begin
                skid_reg <= in_data;
            end
        end
    end

endmodule

// File: rtl/du_ex_skid_reg.sv
// Decoder-to-Ex pipeline register: wraps pipe_skid_buf with payload pack/unpack and occupancy.
// DU_REG_DEBUG_INST_EN adds inst_i/inst_o, carried alongside instAddr.
module du_ex_skid_reg
    import b8_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  du_payload_t pld_i,
`ifdef DU_REG_DEBUG_INST_EN
    input  logic [31:0] inst_i,
    output logic [31:0] inst_o,
`endif
    output logic        valid_o,
    input  logic        ready_i,
    output du_payload_t pld_o,
    output logic [1:0]  occupancy_o
);

    du_payload_t      pld_in;
    logic [PLD_W-1:0] pld_out_bits;
    du_payload_t      pld_out;

    always_comb begin
        pld_in = pld_i;
`ifdef DU_REG_DEBUG_INST_EN
        pld_in.inst = inst_i;
`endif
    end

    pipe_skid_buf #(
        .WIDTH(PLD_W)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush_i),
        .in_valid (valid_i),
        .in_ready (ready_o),
        .in_data  (pld_in),
        .out_valid(valid_o),
        .out_ready(ready_i),
        .out_data (pld_out_bits),
        .count    (occupancy_o)
    );

    assign pld_out = du_payload_t'(pld_out_bits);
    assign pld_o   = pld_out;
`ifdef DU_REG_DEBUG_INST_EN
    assign inst_o  = pld_out.inst;
`endif

endmodule
